// File: rtl/alu_issue_ctrl.sv
// Mini-SRC ALU issue controller with a built-in sequential divider
module alu_issue_ctrl #(
   parameter int unsigned ALU_SETTLE = 1,
   parameter bit          DIV_SIGNED = 1'b1
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  opcode_in,
   input  logic [31:0] ra_val,
   input  logic [31:0] rb_val,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [4:0]  alu_opcode,
   output logic [31:0] alu_y,
   output logic [31:0] alu_b,
   output logic [31:0] alu_a,
   input  logic [63:0] alu_result,
   output logic [31:0] z_hi,
   output logic [31:0] z_lo
);

   localparam int unsigned W         = 32;
   localparam int unsigned OPW       = 5;
   localparam int unsigned CW        = 4;
   localparam int unsigned DCW       = 6;
   localparam int unsigned DIV_ITERS = 32;
   localparam logic [OPW-1:0] OP_DIV = 5'b00011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DIV_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    settle_q;
   logic [DCW-1:0]   div_cnt_q;
   logic [W-1:0]     rem_q;
   logic [W-1:0]     quo_q;
   logic [W-1:0]     dvs_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic [OPW-1:0]   alu_opcode_q;
   logic [W-1:0]     alu_y_q;
   logic [W-1:0]     alu_b_q;
   logic [W-1:0]     alu_a_q;
   logic [W-1:0]     z_hi_q;
   logic [W-1:0]     z_lo_q;

   logic [W-1:0]     ra_mag_d;
   logic [W-1:0]     rb_mag_d;
   logic [W:0]       rem_sh_d;
   logic [W:0]       diff_d;
   logic             ge_d;
   logic [W-1:0]     rem_d;
   logic [W-1:0]     quo_d;
   logic             neg_quo_d;
   logic             neg_rem_d;
   logic [W-1:0]     quo_fin_d;
   logic [W-1:0]     rem_fin_d;

   // Operand magnitudes at accept, one restoring step, and final sign fix-up
   always_comb begin
      ra_mag_d  = ra_val;
      rb_mag_d  = rb_val;
      if (DIV_SIGNED && ra_val[W-1]) ra_mag_d = (~ra_val) + W'(1);
      if (DIV_SIGNED && rb_val[W-1]) rb_mag_d = (~rb_val) + W'(1);

      rem_sh_d  = {rem_q, quo_q[W-1]};
      diff_d    = rem_sh_d - {1'b0, dvs_q};
      ge_d      = (rem_sh_d >= {1'b0, dvs_q});
      rem_d     = ge_d ? diff_d[W-1:0] : rem_sh_d[W-1:0];
      quo_d     = {quo_q[W-2:0], ge_d};

      neg_quo_d = DIV_SIGNED && (alu_y_q[W-1] ^ alu_b_q[W-1]);
      neg_rem_d = DIV_SIGNED && alu_y_q[W-1];
      quo_fin_d = neg_quo_d ? (~quo_q) + W'(1) : quo_q;
      rem_fin_d = neg_rem_d ? (~rem_q) + W'(1) : rem_q;
   end

   // Control FSM, ALU drive registers, divider datapath and Z capture
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q      <= S_IDLE;
         settle_q     <= '0;
         div_cnt_q    <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         dvs_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         dbz_q        <= 1'b0;
         alu_opcode_q <= '0;
         alu_y_q      <= '0;
         alu_b_q      <= '0;
         alu_a_q      <= '0;
         z_hi_q       <= '0;
         z_lo_q       <= '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  alu_opcode_q <= opcode_in;
                  alu_y_q      <= ra_val;
                  alu_a_q      <= ra_val;
                  alu_b_q      <= rb_val;
                  dbz_q        <= 1'b0;
                  busy_q       <= 1'b1;
                  settle_q     <= CW'(ALU_SETTLE - 1);
                  div_cnt_q    <= '0;
                  rem_q        <= '0;
                  quo_q        <= ra_mag_d;
                  dvs_q        <= rb_mag_d;
                  state_q      <= (opcode_in == OP_DIV) ? S_DIV_RUN : S_ISSUE;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_ISSUE: begin
               if (settle_q == '0) begin
                  z_hi_q  <= alu_result[2*W-1:W];
                  z_lo_q  <= alu_result[W-1:0];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  settle_q <= settle_q - CW'(1);
               end
            end
            S_DIV_RUN: begin
               if ((div_cnt_q == '0) && (alu_b_q == '0)) begin
                  // Divide by zero: all-ones quotient, dividend as remainder
                  z_lo_q  <= '1;
                  z_hi_q  <= alu_y_q;
                  dbz_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (div_cnt_q != DCW'(DIV_ITERS)) begin
                  rem_q     <= rem_d;
                  quo_q     <= quo_d;
                  div_cnt_q <= div_cnt_q + DCW'(1);
               end else begin
                  z_lo_q  <= quo_fin_d;
                  z_hi_q  <= rem_fin_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign alu_opcode  = alu_opcode_q;
   assign alu_y       = alu_y_q;
   assign alu_b       = alu_b_q;
   assign alu_a       = alu_a_q;
   assign z_hi        = z_hi_q;
   assign z_lo        = z_lo_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator/consumer side of the Mini-SRC ALU interface.
- Accepts one operation per start handshake, drives latched opcode and operands to the combinational ALU, and waits a programmable settle time.
- Captures the 64-bit ALU result into the Z register pair (z_hi, z_lo).
- DIV (opcode 5'b00011), which the ALU does not implement, is executed internally as a 32-iteration sequential divider.

Parameters:
- ALU_SETTLE, 1, cycles operands are held on the ALU before capture (legal 1..15).
- DIV_SIGNED, 1, 1 = two's-complement divide, 0 = unsigned divide.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- opcode_in  in  5  operation code (ALU encoding).
- ra_val  in  32  first operand (dividend for DIV).
- rb_val  in  32  second operand (divisor or shift count).
- busy  out  1  high in ISSUE and DIV_RUN.
- done  out  1  one-cycle pulse; z_hi and z_lo are valid from this cycle on.
- div_by_zero  out  1  set by DIV with rb_val=0; cleared by the next accepted start.
- alu_opcode  out  5  registered opcode to ALU.
- alu_y  out  32  registered ra_val (ALU Y input).
- alu_b  out  32  registered rb_val (ALU B input).
- alu_a  out  32  registered ra_val (ALU A input; shifts, rotates, NEG).
- alu_result  in  64  ALU Result.
- z_hi  out  32  upper result word; remainder for DIV.
- z_lo  out  32  lower result word; quotient for DIV.

Behaviour:
- Reset: clear=0 at any time, including mid-operation, immediately forces the following. State goes to IDLE. busy, done, div_by_zero = 0. alu_opcode, alu_y, alu_b, alu_a = 0. z_hi, z_lo = 0. Divider state is discarded.
- States: IDLE, ISSUE, DIV_RUN, DONE.
- IDLE or DONE with start=1 at edge E0:
  - Latch opcode_in into alu_opcode, ra_val into alu_y and alu_a, rb_val into alu_b.
  - Clear div_by_zero.
  - Next state is DIV_RUN if opcode is 5'b00011, otherwise ISSUE.
- start while busy=1 is ignored; no queueing.
- ISSUE: settle counter runs ALU_SETTLE cycles. At the edge ending the last ISSUE cycle:
  - z_hi <= alu_result[63:32], z_lo <= alu_result[31:0].
  - State goes to DONE.
  - With ALU_SETTLE=1: capture at E1, done high E1..E2.
- Unimplemented opcodes are still issued; the captured value is whatever the ALU returns (0 by ALU default).
- DONE: done=1 for exactly one cycle, busy=0. Next state is IDLE, or a new operation if start=1.
- DIV_RUN:
  - Restoring shift-subtract, one quotient bit per edge, E1..E32.
  - DIV_SIGNED=1: operate on magnitudes. At E33 the quotient is negated if operand signs differ; the remainder takes the dividend's sign. Quotient truncates toward zero.
  - E33: write z_lo=quotient, z_hi=remainder; state goes to DONE, so done is high E33..E34.
  - 0x80000000 / 0xFFFFFFFF (signed) gives z_lo=0x80000000, z_hi=0, with no flag.
  - alu_opcode stays 5'b00011 during DIV; the ALU output is ignored.
- Divide by zero (rb_val=0):
  - At E1: z_lo=32'hFFFFFFFF, z_hi=ra_val, div_by_zero=1, state goes to DONE.
  - div_by_zero stays high until the next accepted start.
- Between operations, z_hi and z_lo hold their last values; the ALU drive registers also hold.

Test Plan:
- ADD 5+7, ALU_SETTLE=1: start at E0 -> z_lo=12, z_hi=0, done high only in cycle E1..E2, busy high only in E0..E1.
- MUL 0x00010000 x 0x00010000, ALU_SETTLE=3 -> z_hi=1, z_lo=0, done at E3; start pulsed at E1 is ignored.
- Signed DIV -7/2 (ra=0xFFFFFFF9, rb=2) -> done at E33, z_lo=0xFFFFFFFD, z_hi=0xFFFFFFFF, div_by_zero=0. Repeat 100/7 -> z_lo=14, z_hi=2.
- DIV 0x1234/0 -> done at E1, z_lo=0xFFFFFFFF, z_hi=0x1234, div_by_zero=1. A following ADD start clears the flag.
- Back-to-back: SUB 10-3, then start=1 during its DONE cycle for OR 0xF0|0x0F -> first z_lo=7, second z_lo=0xFF, with no idle gap.
- Reset mid-DIV: clear=0 at E10 -> busy=0, z=0, no done pulse. After release, ADD 1+1 -> z_lo=2.
